ram_block_mover: RTL and testbench

Single-port RAM initiator that performs block copy and block fill operations on the 1024 x 32 data RAM. It sits between a control source (CPU-side register or testbench) and the RAM port (`clk`, `we`, `addr`, `din`, `dout`), driving the write-enable, address and write data, and consuming read data. It owns the RAM port exclusively while busy. Overlapping copies follow memmove semantics.

---
 rtl/ram_block_mover.sv | 175 +++++++++++++++++
 tb/tb_ram_block_mover.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// Block copy / block fill engine that owns the single-port data RAM while busy.
// Copies are memmove-safe: overlapping moves to a higher address run top-down.
module ram_block_mover #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [2:0] {IDLE, CHECK, RD, CAP, WR, FIN} state_t;

   localparam logic [ADDR_W:0]   MEM_WORDS = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   state_t              r_state;
   logic                r_mode;
   logic                r_desc;
   logic [ADDR_W-1:0]   r_src;
   logic [ADDR_W-1:0]   r_dst;
   logic [ADDR_W:0]     r_len;
   logic [DATA_W-1:0]   r_fill;
   logic [ADDR_W-1:0]   r_srcPtr;
   logic [ADDR_W-1:0]   r_dstPtr;
   logic [ADDR_W:0]     r_count;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_din;

   logic [ADDR_W:0]     w_dstEnd;
   logic [ADDR_W:0]     w_srcEnd;
   logic                w_rangeBad;
   logic                w_desc;
   logic [ADDR_W-1:0]   w_lenM1;
   logic [ADDR_W-1:0]   w_srcFirst;
   logic [ADDR_W-1:0]   w_dstFirst;
   logic [ADDR_W-1:0]   w_srcNext;
   logic [ADDR_W-1:0]   w_dstNext;
   logic [ADDR_W:0]     w_countNext;

   // Range check uses one extra bit so base+len can reach exactly 1024.
   assign w_dstEnd    = {1'b0, r_dst} + r_len;
   assign w_srcEnd    = {1'b0, r_src} + r_len;
   assign w_rangeBad  = (w_dstEnd > MEM_WORDS) || (!r_mode && (w_srcEnd > MEM_WORDS));
   assign w_desc      = !r_mode && (r_dst > r_src);
   assign w_lenM1     = r_len[ADDR_W-1:0] - PTR_ONE;
   assign w_srcFirst  = w_desc ? (r_src + w_lenM1) : r_src;
   assign w_dstFirst  = w_desc ? (r_dst + w_lenM1) : r_dst;
   assign w_srcNext   = r_desc ? (r_srcPtr - PTR_ONE) : (r_srcPtr + PTR_ONE);
   assign w_dstNext   = r_desc ? (r_dstPtr - PTR_ONE) : (r_dstPtr + PTR_ONE);
   assign w_countNext = r_count + (ADDR_W+1)'(1);

   // RAM port outputs are registered alongside the state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_mode   <= 1'b0;
         r_desc   <= 1'b0;
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_fill   <= '0;
         r_srcPtr <= '0;
         r_dstPtr <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_din    <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_we   <= 1'b0;
         case (r_state)
            // FIN is the done cycle; a new request may already be accepted there.
            IDLE, FIN: begin
               if (start) begin
                  r_mode  <= mode;
                  r_src   <= src_addr;
                  r_dst   <= dst_addr;
                  r_len   <= len;
                  r_fill  <= fill_val;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CHECK;
               end else begin
                  r_state <= IDLE;
               end
            end
            CHECK: begin
               if (w_rangeBad) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_len == '0) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= FIN;
               end else begin
                  r_desc   <= w_desc;
                  r_srcPtr <= w_srcFirst;
                  r_dstPtr <= w_dstFirst;
                  if (r_mode) begin
                     r_we    <= 1'b1;
                     r_addr  <= w_dstFirst;
                     r_din   <= r_fill;
                     r_state <= WR;
                  end else begin
                     r_addr  <= w_srcFirst;
                     r_state <= RD;
                  end
               end
            end
            RD: begin
               r_state <= CAP;
            end
            CAP: begin
               r_we    <= 1'b1;
               r_addr  <= r_dstPtr;
               r_din   <= ram_dout;
               r_state <= WR;
            end
            WR: begin
               r_count  <= w_countNext;
               r_srcPtr <= w_srcNext;
               r_dstPtr <= w_dstNext;
               if (w_countNext == r_len) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= FIN;
               end else if (r_mode) begin
                  r_we    <= 1'b1;
                  r_addr  <= w_dstNext;
                  r_state <= WR;
               end else begin
                  r_addr  <= w_srcNext;
                  r_state <= RD;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign count    = r_count;
   assign ram_we   = r_we;
   assign ram_addr = r_addr;
   assign ram_din  = r_din;

endmodule

// File: tb/tb_ram_block_mover.sv
// Randomized scoreboard bench for ram_block_mover: a memmove/fill reference model
// predicts every RAM write and completion event, and a monitor checks them as they occur.
module tb_ram_block_mover;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int kind;
      int cyc;
      int cnt;
   } ev_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic [9:0]  srcAddr;
   logic [9:0]  dstAddr;
   logic [10:0] len;
   logic [31:0] fillVal;
   logic        busy;
   logic        done;
   logic        err;
   logic [10:0] count;
   logic        ramWe;
   logic [9:0]  ramAddr;
   logic [31:0] ramDin;
   logic [31:0] ramDout;

   logic        preWe;
   logic [9:0]  preAddr;
   logic [31:0] preData;

   logic [31:0] mem    [1024];
   logic [31:0] refMem [1024];

   wr_t wrQ[$];
   ev_t evQ[$];
   int  evSeen = 0;
   int  cyc = 0;
   int  nChecks = 0;
   int  nPass = 0;

   ram_block_mover #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .src_addr (srcAddr),
      .dst_addr (dstAddr),
      .len      (len),
      .fill_val (fillVal),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .count    (count),
      .ram_we   (ramWe),
      .ram_addr (ramAddr),
      .ram_din  (ramDin),
      .ram_dout (ramDout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous read-first RAM, with a bench-only port used for preloading.
   always @(posedge clk) begin
      if (preWe) mem[preAddr] <= preData;
      else if (ramWe) mem[ramAddr] <= ramDin;
      ramDout <= mem[ramAddr];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every write and every done/err pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (ramWe) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpected write", {54'd0, ramAddr}, 64'hFFFF);
            end else begin
               wr_t w;
               w = wrQ.pop_front();
               checkOutput("write addr", {54'd0, ramAddr}, 64'(w.addr));
               checkOutput("write data", {32'd0, ramDin}, {32'd0, w.data});
            end
         end
         if (done || err) begin
            if (evQ.size() == 0) begin
               checkOutput("unexpected done/err", {62'd0, done, err}, 64'd0);
            end else begin
               ev_t e;
               e = evQ.pop_front();
               checkOutput("err flag", {63'd0, err}, 64'(e.kind));
               checkOutput("done flag", {63'd0, done}, 64'(1 - e.kind));
               checkOutput("completion cycle", 64'(cyc), 64'(e.cyc));
               checkOutput("busy at end", {63'd0, busy}, 64'd0);
               checkOutput("count at end", {53'd0, count}, 64'(e.cnt));
               evSeen++;
            end
         end
      end
   end

   task automatic preloadWord(input int a, input logic [31:0] d);
      @(negedge clk);
      preWe = 1'b1; preAddr = 10'(a); preData = d;
      refMem[a] = d;
      @(negedge clk);
      preWe = 1'b0;
   endtask

   task automatic printSummaryAndFinish();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   endtask

   task automatic applyStimulus(input bit m, input int s, input int d, input int l,
                                input logic [31:0] f, input bit inject);
      int          e;
      int          target;
      bit          bad;
      ev_t         ev;
      logic [31:0] snap[$];
      bad = (d + l > 1024) || (!m && (s + l > 1024));
      @(negedge clk);
      start = 1'b1; mode = m; srcAddr = 10'(s); dstAddr = 10'(d); len = 11'(l); fillVal = f;
      e = cyc + 1;
      if (bad) begin
         ev = '{1, e + 1, 0};
      end else if (l == 0) begin
         ev = '{0, e + 1, 0};
      end else if (m) begin
         for (int i = 0; i < l; i++) begin
            wrQ.push_back('{d + i, f});
            refMem[d + i] = f;
         end
         ev = '{0, e + l + 1, l};
      end else begin
         for (int i = 0; i < l; i++) snap.push_back(refMem[s + i]);
         if (d > s) for (int i = l - 1; i >= 0; i--) wrQ.push_back('{d + i, snap[i]});
         else       for (int i = 0; i < l; i++)      wrQ.push_back('{d + i, snap[i]});
         for (int i = 0; i < l; i++) refMem[d + i] = snap[i];
         ev = '{0, e + 3 * l + 1, l};
      end
      evQ.push_back(ev);
      target = evSeen + 1;
      @(negedge clk);
      start = 1'b0;
      srcAddr = 10'($urandom); dstAddr = 10'($urandom); len = 11'($urandom); fillVal = $urandom;
      mode = ~m;
      checkOutput("busy after start", {63'd0, busy}, 64'd1);
      if (inject) begin
         @(negedge clk);
         start = 1'b1; mode = 1'b1; dstAddr = 10'd500; len = 11'd5;
         @(negedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 3 * l + 20 && evSeen < target; k++) @(negedge clk);
      if (evSeen < target) begin
         checkOutput("completion timeout", 64'd0, 64'd1);
         printSummaryAndFinish();
      end
      @(negedge clk);
      checkOutput("count held", {53'd0, count}, 64'(ev.cnt));
      checkOutput("writes outstanding", 64'(wrQ.size()), 64'd0);
   endtask

   task automatic checkMemory(input string name);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 1024; i++) begin
         if (mem[i] !== refMem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      if (first >= 0) $display("[TB] first differing word at %0d: %0h vs model %0h", first, mem[first], refMem[first]);
      checkOutput(name, 64'(bad), 64'd0);
   endtask

   task automatic resetMidFill();
      @(negedge clk);
      start = 1'b1; mode = 1'b1; dstAddr = 10'd300; len = 11'd10; fillVal = 32'hA5A5_0F0F;
      for (int i = 0; i < 2; i++) begin
         wrQ.push_back('{300 + i, 32'hA5A5_0F0F});
         refMem[300 + i] = 32'hA5A5_0F0F;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst ram_we", {63'd0, ramWe}, 64'd0);
      checkOutput("rst busy", {63'd0, busy}, 64'd0);
      checkOutput("rst count", {53'd0, count}, 64'd0);
      checkOutput("rst ram_addr", {54'd0, ramAddr}, 64'd0);
      checkOutput("rst ram_din", {32'd0, ramDin}, 64'd0);
      checkOutput("rst done/err", {62'd0, done, err}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("writes before reset", 64'(wrQ.size()), 64'd0);
      checkMemory("memory after reset");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; srcAddr = '0; dstAddr = '0;
      len = '0; fillVal = '0; preWe = 1'b0; preAddr = '0; preData = '0;
      #1;
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset err", {63'd0, err}, 64'd0);
      checkOutput("reset count", {53'd0, count}, 64'd0);
      checkOutput("reset ram_we", {63'd0, ramWe}, 64'd0);
      checkOutput("reset ram_addr", {54'd0, ramAddr}, 64'd0);
      checkOutput("reset ram_din", {32'd0, ramDin}, 64'd0);
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         preWe = 1'b1; preAddr = 10'(i); preData = $urandom;
         refMem[i] = preData;
      end
      @(negedge clk);
      preWe = 1'b0;
      reset = 1'b0;

      applyStimulus(1'b1, 0, 100, 4, 32'hDEAD_BEEF, 1'b0);
      preloadWord(10, 32'd1); preloadWord(11, 32'd2); preloadWord(12, 32'd3);
      applyStimulus(1'b0, 10, 20, 3, 32'h0, 1'b1);
      preloadWord(0, 32'd5); preloadWord(1, 32'd6); preloadWord(2, 32'd7); preloadWord(3, 32'd8);
      applyStimulus(1'b0, 0, 2, 4, 32'h0, 1'b0);
      applyStimulus(1'b1, 0, 1022, 3, 32'h1234_5678, 1'b0);
      applyStimulus(1'b0, 7, 50, 0, 32'h0, 1'b0);
      applyStimulus(1'b1, 0, 1020, 4, 32'hCAFE_F00D, 1'b0);
      applyStimulus(1'b0, 1021, 40, 4, 32'h0, 1'b0);
      applyStimulus(1'b0, 200, 200, 5, 32'h0, 1'b0);
      applyStimulus(1'b0, 64, 60, 8, 32'h0, 1'b0);
      applyStimulus(1'b0, 1019, 1000, 5, 32'h0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1024, 32'h0, 1'b0);
      applyStimulus(1'b1, 0, 0, 1024, 32'h0F0F_1234, 1'b0);
      checkMemory("memory after directed ops");
      for (int i = 0; i < 1024; i++) preloadWord(i, $urandom);
      resetMidFill();

      for (int n = 0; n < 40; n++) begin
         int s = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
         int d = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
         if ($urandom_range(0, 2) == 0) d = s + $urandom_range(0, 6) - 3;
         if (d < 0) d = 0;
         if (d > 1023) d = 1023;
         applyStimulus(1'($urandom_range(0, 1)), s, d, $urandom_range(0, 24), $urandom, 1'b0);
      end
      checkMemory("memory after random ops");
      printSummaryAndFinish();
   end

endmodule
